// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debouncer: FSM state encoding, default timing,
// and the elaboration-time counter-width legality check.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'b00,
    WAIT_HI = 2'b01,
    ST_HI   = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_CNT_W         = 16;

  // The counter must be able to hold STABLE_CYCLES-1 without wrapping.
  function automatic bit cnt_w_ok(input int stable_cycles, input int cnt_w);
    return (cnt_w > 0) && (cnt_w < 32) && ((64'd1 << cnt_w) > 64'(stable_cycles));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; 2-edge latency, no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw async input into q_level with one-cycle rise/fall strobes.
// Latency 1+STABLE_CYCLES edges after capture into the synchroniser; no backpressure.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q_level,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (!cnt_w_ok(STABLE_CYCLES, CNT_W) || (STABLE_CYCLES < 2)) begin : g_bad_param
    $fatal(1, "debounce_edge: STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync2;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (sync2)
  );

  // Any reversion of sync2 while waiting drops back to the settled state,
  // so a glitch restarts qualification from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_LO;
      cnt     <= '0;
      q_level <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO: begin
          if (sync2) begin
            state <= WAIT_HI;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync2) begin
            state <= ST_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_HI;
            q_level <= 1'b1;
            rise    <= 1'b1;
            cnt     <= '0;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HI: begin
          if (!sync2) begin
            state <= WAIT_LO;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LO: begin
          if (sync2) begin
            state <= ST_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_LO;
            q_level <= 1'b0;
            fall    <= 1'b1;
            cnt     <= '0;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LO;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
